// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared debug-dump definitions: dump length defaults and controller state encoding.
// Imported by the debug unit and the dump controller so both agree on the dump size.
package regfile_dump_ctrl_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_SEND,
        ST_DONE
    } dump_state_t;

    // Counter width that stays legal when only one byte per word is sent.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_dump_ctrl_word_serializer.sv
// Word-to-byte serializer, MSB first, with valid/ready handshake.
// Reusable for any word dump (register file, PC, latches).
module word_serializer
    import regfile_dump_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_valid,
    input  logic              i_ready,
    output logic [7:0]        o_byte,
    output logic              o_last
);

    localparam int BYTES_PER_REG = DATA_W / 8;
    localparam int CNT_W         = cnt_width(BYTES_PER_REG);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_xfer;

    assign w_xfer = i_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_load_data;
            r_cnt   <= '0;
        end else if (w_xfer) begin
            r_shift <= r_shift << 8;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_byte = r_shift[DATA_W-1 -: 8];
    assign o_last = (r_cnt == CNT_W'(BYTES_PER_REG - 1));

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Register file dump controller: walks the read port in address order and streams
// each register MSB first to the UART TX, holding the pipeline stalled meanwhile.
module regfile_dump_ctrl
    import regfile_dump_ctrl_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cpu_stall,
    output logic [ADDR_W-1:0] o_rf_read_addr,
    input  logic [DATA_W-1:0] i_rf_read_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready
);

    dump_state_t       r_state;
    dump_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              w_load;
    logic              w_last_byte;
    logic              w_xfer;
    logic              w_last_addr;
    logic              w_tx_valid;

    assign w_tx_valid  = (r_state == ST_SEND);
    assign w_xfer      = w_tx_valid && i_tx_ready;
    assign w_last_addr = (r_addr == ADDR_W'(NUM_REGS - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE:    if (i_start) w_state_nxt = ST_ISSUE;
            ST_ISSUE:   w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                w_load      = 1'b1;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_xfer && w_last_byte) begin
                    w_state_nxt = w_last_addr ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Address only advances between registers, so it is frozen through tx stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_addr <= '0;
        end else if (w_xfer && w_last_byte && !w_last_addr) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    word_serializer #(
        .DATA_W (DATA_W)
    ) u_word_serializer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_load),
        .i_load_data (i_rf_read_data),
        .i_valid     (w_tx_valid),
        .i_ready     (i_tx_ready),
        .o_byte      (o_tx_data),
        .o_last      (w_last_byte)
    );

    assign o_busy         = (r_state != ST_IDLE);
    assign o_cpu_stall    = o_busy;
    assign o_done         = (r_state == ST_DONE);
    assign o_tx_valid     = w_tx_valid;
    assign o_rf_read_addr = r_addr;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: register file model plus expected byte stream
// derived directly from the register contents (MSB first, address order).
module tb_regfile_dump_ctrl;

    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int BPR = DW / 8;
    localparam int NB  = NR * BPR;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic          o_busy;
    logic          o_done;
    logic          o_cpu_stall;
    logic [AW-1:0] o_rf_read_addr;
    logic [DW-1:0] i_rf_read_data;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready;

    logic [DW-1:0] rf [NR];
    logic [7:0]    got [$];
    logic [7:0]    ref_stream [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign i_rf_read_data = rf[o_rf_read_addr];

    regfile_dump_ctrl #(
        .NUM_REGS (NR),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_cpu_stall    (o_cpu_stall),
        .o_rf_read_addr (o_rf_read_addr),
        .i_rf_read_data (i_rf_read_data),
        .o_tx_data      (o_tx_data),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (i_tx_ready)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] got_word(input int idx);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            w = w << 8;
            if (idx + k < got.size()) w[7:0] = got[idx + k];
        end
        return w;
    endfunction

    // One full dump; start pulses at cycles 5, 100 and 193 when extra_starts is set.
    task automatic run_dump(input int ready_pct, input bit extra_starts);
        logic [7:0] exp_q [$];
        logic       prev_valid;
        logic       prev_ready;
        logic [7:0] prev_data;
        bit         finished;
        int         done_cnt, done_cycle, busy_after, stall_cnt, stall_gap;
        int         stall_bad, unstable, max_addr, busy_c1, addr_c1, mism;

        for (int r = 0; r < NR; r++)
            for (int b = BPR - 1; b >= 0; b--)
                exp_q.push_back(rf[r][8*b +: 8]);

        got.delete();
        prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
        finished = 1'b0;
        done_cnt = 0; done_cycle = -1; busy_after = 1; stall_cnt = 0; stall_gap = 0;
        stall_bad = 0; unstable = 0; max_addr = 0; busy_c1 = 0; addr_c1 = -1; mism = 0;

        for (int c = 0; c < 3000 && !finished; c++) begin
            @(negedge clk);
            i_start    = (c == 0) || (extra_starts && (c == 5 || c == 100 || c == 193));
            i_tx_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < ready_pct);
            #1;
            if (c == 1) begin
                busy_c1 = int'(o_busy);
                addr_c1 = int'(o_rf_read_addr);
            end
            if (prev_valid && !prev_ready && (!o_tx_valid || o_tx_data !== prev_data)) unstable++;
            if (o_busy !== o_cpu_stall) stall_bad++;
            if (int'(o_rf_read_addr) > max_addr) max_addr = int'(o_rf_read_addr);
            if (done_cycle >= 0) begin
                busy_after = int'(o_busy);
                if (o_done) done_cnt++;
                finished = 1'b1;
            end else begin
                if (c >= 1 && !o_done) begin
                    if (o_cpu_stall) stall_cnt++;
                    else stall_gap++;
                end
                if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
                if (o_done) begin
                    done_cnt++;
                    done_cycle = c;
                end
            end
            prev_valid = o_tx_valid; prev_ready = i_tx_ready; prev_data = o_tx_data;
        end
        i_start = 1'b0;

        for (int i = 0; i < NB; i++)
            if (i >= got.size() || got[i] !== exp_q[i]) mism++;

        check_val("done_seen", 32'(done_cycle >= 0), 32'd1);
        check_val("byte_count", 32'(got.size()), 32'(NB));
        check_val("byte_mismatches", 32'(mism), 32'd0);
        check_val("done_pulses", 32'(done_cnt), 32'd1);
        check_val("busy_after_done", 32'(busy_after), 32'd0);
        check_val("busy_cycle1", 32'(busy_c1), 32'd1);
        check_val("addr_cycle1", 32'(addr_c1), 32'd0);
        check_val("addr_max", 32'(max_addr), 32'(NR - 1));
        check_val("tx_unstable", 32'(unstable), 32'd0);
        check_val("stall_ne_busy", 32'(stall_bad), 32'd0);
        check_val("stall_gap", 32'(stall_gap), 32'd0);
        if (ready_pct >= 100) begin
            check_val("done_cycle", 32'(done_cycle), 32'd193);
            check_val("stall_cycles", 32'(stall_cnt), 32'd192);
        end
    endtask

    initial begin
        int n;
        int mism;

        i_rst = 1'b1; i_start = 1'b0; i_tx_ready = 1'b0;
        for (int r = 0; r < NR; r++) rf[r] = $urandom;
        rf[0] = 32'h0; rf[1] = 32'h11; rf[2] = 32'h12; rf[8] = 32'h4;

        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        #1;
        check_val("rst_busy", 32'(o_busy), 32'd0);
        check_val("rst_done", 32'(o_done), 32'd0);
        check_val("rst_stall", 32'(o_cpu_stall), 32'd0);
        check_val("rst_valid", 32'(o_tx_valid), 32'd0);
        check_val("rst_addr", 32'(o_rf_read_addr), 32'd0);
        check_val("rst_tx_data", 32'(o_tx_data), 32'd0);

        // Full-rate dump with known leading registers
        run_dump(100, 1'b0);
        check_val("r0_bytes", got_word(0), 32'h0000_0000);
        check_val("r1_bytes", got_word(4), 32'h0000_0011);
        check_val("r2_bytes", got_word(8), 32'h0000_0012);
        check_val("r8_bytes", got_word(32), 32'h0000_0004);
        ref_stream = got;

        // Random back-pressure must not change the stream
        run_dump(30, 1'b0);
        mism = 0;
        for (int i = 0; i < NB; i++)
            if (i >= got.size() || got[i] !== ref_stream[i]) mism++;
        check_val("stalled_vs_fullrate", 32'(mism), 32'd0);

        rf[31] = 32'hDEAD_BEEF;
        run_dump(100, 1'b0);
        check_val("r31_bytes", got_word(NB - 4), 32'hDEAD_BEEF);

        // start pulses mid-dump and in the DONE cycle
        run_dump(100, 1'b1);

        // Reset in SEND of r10 byte 2 while UART is stalled
        n = 0;
        for (int k = 0; k < 1000 && n < 42; k++) begin
            @(negedge clk);
            i_start    = (k == 0);
            i_tx_ready = 1'b1;
            #1;
            if (o_tx_valid) n++;
        end
        @(negedge clk);
        i_start = 1'b0; i_tx_ready = 1'b0; i_rst = 1'b1;
        #1;
        check_val("pre_rst_addr", 32'(o_rf_read_addr), 32'd10);
        check_val("pre_rst_valid", 32'(o_tx_valid), 32'd1);
        check_val("pre_rst_byte", 32'(o_tx_data), 32'(rf[10][15:8]));
        @(negedge clk);
        i_rst = 1'b0;
        #1;
        check_val("post_rst_valid", 32'(o_tx_valid), 32'd0);
        check_val("post_rst_busy", 32'(o_busy), 32'd0);
        check_val("post_rst_stall", 32'(o_cpu_stall), 32'd0);
        check_val("post_rst_addr", 32'(o_rf_read_addr), 32'd0);
        run_dump(100, 1'b0);
        check_val("restart_r0", got_word(0), rf[0]);

        // rst and start together: rst wins
        @(negedge clk);
        i_rst = 1'b1; i_start = 1'b1;
        #1;
        @(negedge clk);
        i_rst = 1'b0; i_start = 1'b0;
        #1;
        check_val("rst_start_idle", 32'(o_busy), 32'd0);
        @(negedge clk);
        #1;
        check_val("rst_start_still_idle", 32'(o_busy), 32'd0);
        run_dump(100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump_ctrl.md
# regfile_dump_ctrl

Debug-side controller that sequences the register file's read port to dump all registers, in address order, as a byte stream to the UART transmitter. It sits between the debug unit, the register file read port and the UART TX. While it runs, it holds the CPU pipeline stalled so register contents are frozen.

## Interface
Parameters:
- NUM_REGS, 32, registers dumped (addresses 0..NUM_REGS-1)
- ADDR_W, 5, register address width
- DATA_W, 32, register width; must be a multiple of 8
- BYTES_PER_REG, DATA_W/8, derived; bytes sent per register

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- busy  out  1  high from the cycle after an accepted start until DONE is left
- done  out  1  one-cycle pulse after the last byte is accepted
- cpu_stall  out  1  pipeline freeze; equal to busy
- rf_read_addr  out  ADDR_W  address driven to the register file read port
- rf_read_data  in  DATA_W  register file read data; valid one full cycle after rf_read_addr is stable
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART TX accepts; a byte transfers on a cycle with tx_valid && tx_ready

## Operation
- FSM states:
  - IDLE -> ISSUE on start.
  - ISSUE: address stable for one cycle -> CAPTURE.
  - CAPTURE: at the end of the cycle, load rf_read_data into a shift register and clear the byte counter -> SEND.
  - SEND: tx_valid=1. On each transfer, shift and increment the byte counter. After byte BYTES_PER_REG-1 transfers:
    - if rf_read_addr == NUM_REGS-1 -> DONE;
    - else increment rf_read_addr -> ISSUE.
  - DONE: done=1 for one cycle -> IDLE.
- Byte order is MSB first: tx_data = shift_reg[DATA_W-1 -: 8], and the register shifts left by 8 per transfer.
- rf_read_addr is cleared to 0 on accepting start. It never wraps past NUM_REGS-1.
- Register 0 is dumped like any other register; no special casing.
- start while busy (any state other than IDLE) is ignored; there is no queueing.
- tx_data must hold stable while tx_valid=1 and tx_ready=0. tx_valid never drops without a transfer, except on rst.
- Counters: byte counter width is clog2(BYTES_PER_REG). Address increments are ADDR_W-bit unsigned.

## Timing
- Reset values:
  - state IDLE; busy=0, done=0, cpu_stall=0, tx_valid=0
  - rf_read_addr=0, tx_data=0, shift register=0
- Cycle 0: start=1 in IDLE. Cycle 1: ISSUE, busy=cpu_stall=1, addr=0. Cycle 2: CAPTURE. Cycle 3: first tx_valid.
- With tx_ready tied high, each register takes 2+BYTES_PER_REG cycles (6 with defaults).
  - A full default dump is 192 busy cycles, followed by 1 DONE cycle.
  - done is high in cycle 193; busy=0 from cycle 194.
- tx_ready stalls extend SEND only; the address and shift register are unchanged during a stall.
- rst asserted in any state: at the next edge, return to reset values. tx_valid drops even mid-byte; the partial dump is discarded.
- rst and start in the same cycle: rst wins and the controller stays IDLE.
- start in the DONE cycle is ignored; a new start is accepted from IDLE one cycle later.

## Structure
- Shared package (debug package): FSM state enum (IDLE, ISSUE, CAPTURE, SEND, DONE) and the NUM_REGS/ADDR_W/DATA_W defaults, so the debug unit and top level agree on dump length.
- One natural sub-module: word_serializer. It holds the shift register and byte counter, with load/valid/ready in and last-byte out, and is reusable for PC/latch dumps. The FSM and address counter stay in regfile_dump_ctrl.

## Test plan
- Reset defaults, tx_ready=1, start: the stream begins 00 00 00 00 (r0), 00 00 00 11 (r1), 00 00 00 12 (r2). Bytes 32..35 are 00 00 00 04 (r8). There are 128 bytes total. done pulses in cycle 193 and cpu_stall is high for cycles 1..192.
- Random tx_ready (~30% duty): byte sequence is identical to the previous test. tx_data is stable across every stalled cycle, and no byte is duplicated or dropped.
- Model writes 0xDEADBEEF to r31 before start: the last four bytes are DE AD BE EF, then done. rf_read_addr never exceeds 31.
- start pulsed again at cycles 5 and 100 mid-dump: no effect. Exactly 128 bytes and one done pulse.
- rst asserted in SEND during r10 byte 2 with tx_ready=0: next cycle tx_valid=0, busy=0, cpu_stall=0, rf_read_addr=0. A fresh start restarts from r0.
- rst and start asserted together: the controller stays IDLE. start alone in the following cycle begins the dump, with busy=1 one cycle later.
